ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/ctrl_decode.sv | 33 +++
 rtl/ctrl_pipe.sv | 105 ++++++++++
 tb/tb_ctrl_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode map, ALU op codes, FSM states and shift-op flags for ctrl_pipe.
package ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_COM = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_COM = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Bit i set when ALU op i takes an immediate/shift-amount operand.
    localparam logic [7:0] SHIFT_OPS = 8'b1100_0000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
//   op         in   opcode; op[2:0] is the ALU op field, op[OP_W-1] selects the NOP/illegal space
//   wen        out  single-cycle register write (MUL writes back later, so 0 here)
//   alusrc     out  immediate/shift-amount operand
//   aluop      out  ALU operation, zero for NOP/illegal
//   is_mul     out  multi-cycle multiply
//   is_illegal out  1xxx opcode other than NOP
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    op,
    output logic               wen,
    output logic               alusrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               is_mul,
    output logic               is_illegal
);

    logic ext;

    always_comb begin
        ext        = op[OP_W-1];
        is_mul     = op == OP_W'(OP_MUL);
        is_illegal = ext && op != OP_W'(OP_NOP);
        wen        = !ext && !is_mul;
        alusrc     = !ext && SHIFT_OPS[op[2:0]];
        aluop      = ext ? '0 : ALUOP_W'(op[2:0]);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered, handshaked control decoder with multi-cycle MUL sequencing and flush.
//   clk, rst_n         core clock, asynchronous active-low reset
//   in_valid/in_ready  opcode handshake from ID; in_op opcode, in_rd destination register
//   flush              synchronous kill of in-flight work, beats accept
//   ex_valid           EX control valid; aluop/alusrc ALU control
//   wen/wb_rd          register-file write enable and address
//   trap/trap_clr      sticky illegal-opcode flag and its clear (only with CTRL_ILLEGAL_TRAP_EN)
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int ALUOP_W    = 3,
    parameter int RA_W       = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [RA_W-1:0]    in_rd,
    input  logic               flush,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrc,
    output logic               wen,
    output logic [RA_W-1:0]    wb_rd
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic               trap,
    input  logic               trap_clr
`endif
);

    localparam int CNT_W = 4;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               dec_wen;
    logic               dec_alusrc;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_is_mul;
    logic               dec_is_illegal;

    ctrl_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_decode (
        .op         (in_op),
        .wen        (dec_wen),
        .alusrc     (dec_alusrc),
        .aluop      (dec_aluop),
        .is_mul     (dec_is_mul),
        .is_illegal (dec_is_illegal)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            trap <= 1'b0;
        else if (accept && dec_is_illegal)
            trap <= 1'b1;
        else if (trap_clr)
            trap <= 1'b0;

    assign in_ready = rst_n && state == IDLE && !flush && !trap;
`else
    assign in_ready = rst_n && state == IDLE && !flush;
`endif

    assign accept = in_valid && in_ready;

    // The write-back is registered on the edge where cnt==1, so the wen cycle
    // already sees IDLE and can accept the next opcode at full rate.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ex_valid <= 1'b0;
            aluop    <= '0;
            alusrc   <= 1'b0;
            wen      <= 1'b0;
            wb_rd    <= '0;
        end else if (flush) begin
            state    <= IDLE;
            cnt      <= '0;
            ex_valid <= 1'b0;
            wen      <= 1'b0;
        end else if (state == MUL) begin
            ex_valid <= 1'b0;
            cnt      <= cnt - 1'b1;
            wen      <= cnt == CNT_W'(1);
            state    <= cnt == CNT_W'(1) ? IDLE : MUL;
        end else if (accept) begin
            ex_valid <= dec_wen || dec_is_mul;
            aluop    <= dec_aluop;
            alusrc   <= dec_alusrc;
            wen      <= dec_wen;
            wb_rd    <= (dec_wen || dec_is_mul) ? in_rd : '0;
            state    <= dec_is_mul ? MUL : IDLE;
            cnt      <= dec_is_mul ? CNT_W'(MUL_CYCLES - 1) : '0;
        end else begin
            ex_valid <= 1'b0;
            wen      <= 1'b0;
        end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe with MUL_CYCLES=3.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_rd;
    logic       flush;
    logic       ex_valid;
    logic [2:0] aluop;
    logic       alusrc;
    logic       wen;
    logic [3:0] wb_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       trap;
    logic       trap_clr = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int stepno   = 0;
    logic [9:0] sb[$];

    ctrl_pipe #(.OP_W(4), .ALUOP_W(3), .RA_W(4), .MUL_CYCLES(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .flush    (flush),
        .ex_valid (ex_valid),
        .aluop    (aluop),
        .alusrc   (alusrc),
        .wen      (wen),
        .wb_rd    (wb_rd)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .trap     (trap),
        .trap_clr (trap_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", tag, stepno, got, exp);
        end
    endtask

    function automatic logic [9:0] pk(input logic ev, input logic [2:0] a, input logic s,
                                      input logic w, input logic [3:0] r);
        return {ev, a, s, w, r};
    endfunction

    function automatic logic [9:0] outs();
        return {ex_valid, aluop, alusrc, wen, wb_rd};
    endfunction

    // Drive one cycle of stimulus, check in_ready for this cycle, then compare
    // the registered outputs produced by the following edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] rd,
                        input logic fl, input logic rdy, input logic [9:0] exp);
        logic [9:0] e;
        stepno++;
        in_valid = v;
        in_op    = op;
        in_rd    = rd;
        flush    = fl;
        #1;
        check("in_ready", 16'(in_ready), 16'(rdy));
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 16'(1), 16'(0));
        end else begin
            e = sb.pop_front();
            check("outputs", 16'(outs()), 16'(e));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        flush    = 1'b0;
        #12;
        check("reset_outs", 16'(outs()), 16'(0));
        check("reset_rdy", 16'(in_ready), 16'(0));
        rst_n = 1'b1;
        #1;
        check("rel_rdy", 16'(in_ready), 16'(1));
        @(posedge clk);
        #1;

        step(1, OP_ADD, 4'd1, 0, 1, pk(1, ALU_ADD, 0, 1, 4'd1));
        step(1, OP_SLL, 4'd2, 0, 1, pk(1, ALU_SLL, 1, 1, 4'd2));
        step(1, OP_XOR, 4'd3, 0, 1, pk(1, ALU_XOR, 0, 1, 4'd3));
        step(0, OP_ADD, 4'd0, 0, 1, pk(0, ALU_XOR, 0, 0, 4'd3));

        step(1, OP_MUL, 4'd5, 0, 1, pk(1, ALU_MUL, 0, 0, 4'd5));
        step(1, OP_ADD, 4'd7, 0, 0, pk(0, ALU_MUL, 0, 0, 4'd5));
        step(1, OP_ADD, 4'd7, 0, 0, pk(0, ALU_MUL, 0, 1, 4'd5));
        step(1, OP_ADD, 4'd7, 0, 1, pk(1, ALU_ADD, 0, 1, 4'd7));

        step(1, OP_MUL, 4'd6, 0, 1, pk(1, ALU_MUL, 0, 0, 4'd6));
        step(0, OP_ADD, 4'd0, 0, 0, pk(0, ALU_MUL, 0, 0, 4'd6));
        step(0, OP_ADD, 4'd0, 1, 0, pk(0, ALU_MUL, 0, 0, 4'd6));
        step(0, OP_ADD, 4'd0, 0, 1, pk(0, ALU_MUL, 0, 0, 4'd6));

        step(1, OP_NOP, 4'd9, 0, 1, pk(0, 3'b000, 0, 0, 4'd0));
        step(1, OP_ADD, 4'd4, 0, 1, pk(1, ALU_ADD, 0, 1, 4'd4));
        step(1, 4'b1010, 4'd8, 0, 1, pk(0, 3'b000, 0, 0, 4'd0));
        step(1, OP_ADD, 4'd1, 1, 0, pk(0, 3'b000, 0, 0, 4'd0));
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("trap_set", 16'(trap), 16'(1));
        step(1, OP_ADD, 4'd1, 0, 0, pk(0, 3'b000, 0, 0, 4'd0));
        trap_clr = 1'b1;
        step(0, OP_ADD, 4'd0, 0, 0, pk(0, 3'b000, 0, 0, 4'd0));
        trap_clr = 1'b0;
        check("trap_clr", 16'(trap), 16'(0));
`endif
        step(1, OP_COM, 4'd10, 0, 1, pk(1, ALU_COM, 0, 1, 4'd10));
        step(1, OP_SRL, 4'd11, 0, 1, pk(1, ALU_SRL, 1, 1, 4'd11));

        step(1, OP_MUL, 4'd12, 0, 1, pk(1, ALU_MUL, 0, 0, 4'd12));
        step(0, OP_ADD, 4'd0, 0, 0, pk(0, ALU_MUL, 0, 0, 4'd12));
        step(0, OP_ADD, 4'd0, 0, 0, pk(0, ALU_MUL, 0, 1, 4'd12));
        step(1, OP_ADD, 4'd1, 1, 0, pk(0, ALU_MUL, 0, 0, 4'd12));
        step(0, OP_ADD, 4'd0, 0, 1, pk(0, ALU_MUL, 0, 0, 4'd12));

        step(1, OP_MUL, 4'd13, 0, 1, pk(1, ALU_MUL, 0, 0, 4'd13));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 16'(outs()), 16'(0));
        check("async_rst_rdy", 16'(in_ready), 16'(0));
        #1;
        rst_n = 1'b1;
        #1;
        check("async_rel_rdy", 16'(in_ready), 16'(1));
        for (int i = 0; i < 4; i++)
            step(0, OP_ADD, 4'd0, 0, 1, pk(0, 3'b000, 0, 0, 4'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
